spi_eeprom_sequencer: RTL and testbench
=======================================

SPI_EEPROM_SEQUENCER -- requirements
Module: spi_eeprom_sequencer

Interface
REQ-001 Parameter BASE_ADDRESS, default 32'hFFFF0000: AXI-Lite base of the AXI-SPI peripheral.
REQ-002 Parameter CMD_WORD, default 32'h30000000: command-register value (CPOL=0, CPHA=0, SCK=ACLK/16).
REQ-003 Parameter TWC_CYCLES, default 500000: EEPROM internal write-cycle wait in ACLK cycles (5 ms at 100 MHz).
REQ-004 Parameter POLL_LIMIT, default 4096: maximum status polls per frame before error.
REQ-005 Ports: ACLK input 1 (clock); ARESET input 1 (sync reset, active-high); one clock, all logic on posedge ACLK.
REQ-006 Request: req_valid in 1; req_ready out 1; req_write in 1 (1=write byte, 0=read byte); req_addr in 16 (EEPROM address); req_wdata in 8.
REQ-007 Response: done out 1 (one-cycle pulse); rdata out 8 (read byte, valid with done); err out 1 (poll timeout, valid with done).
REQ-008 AXI-Lite master write: AWVALID out 1; AWREADY in 1; AWADDR out 32; WVALID out 1; WREADY in 1; WDATA out 32 (no B channel).
REQ-009 AXI-Lite master read: ARVALID out 1; ARREADY in 1; ARADDR out 32; RVALID in 1; RREADY out 1; RDATA in 32.

Function
REQ-010 Register offsets: RX FIFO +0x0, STATUS +0x4, COMMAND +0x8, TX FIFO +0xC; STATUS bit0 = BUSY (TX FIFO non-empty or frame in progress); CS_N deasserts when BUSY falls.
REQ-011 States: CFG, IDLE, PUSH, POLL_AR, POLL_R, DRAIN_AR, DRAIN_R, TWC, DONE.
REQ-012 CFG (entered from reset): one AXI write of CMD_WORD to BASE+0x8, then IDLE; req_ready=0 until IDLE.
REQ-013 AXI write: AWVALID and WVALID asserted in the same cycle, each held until its READY sampled high, deasserted individually; write complete when both handshakes done; AWADDR/WDATA stable while VALID high.
REQ-014 AXI read: ARVALID held until ARREADY; then RREADY=1 until RVALID; RDATA captured on the RVALID&RREADY cycle.
REQ-015 IDLE: req_ready=1; req_valid&req_ready latches req_write, req_addr, req_wdata; req_ready=0 next cycle until DONE exits.
REQ-016 Write request frames: frame A = {0x06 WREN}; frame B = {0x02, addr[15:8], addr[7:0], wdata}; each byte one AXI write to BASE+0xC, WDATA={24'h0,byte}, bytes back-to-back.
REQ-017 After each frame's last byte: POLL_AR/POLL_R read BASE+0x4 repeatedly until bit0=0; next frame starts only after BUSY=0.
REQ-018 After frame B idle: TWC counts TWC_CYCLES cycles (counter width ceil(log2(TWC_CYCLES+1))), then DONE.
REQ-019 Read request frame: {0x03, addr[15:8], addr[7:0], 0x00}; after BUSY=0, DRAIN reads BASE+0x0 exactly 4 times; rdata = RDATA[7:0] of 4th read; first three discarded.
REQ-020 Poll counter reset per frame; on reaching POLL_LIMIT polls with BUSY still 1: abort remaining frames/drain/TWC, go DONE with err=1.
REQ-021 DONE: done=1 for exactly one cycle, err/rdata valid that cycle, then IDLE; rdata holds value until next read completes.
REQ-022 Write requests leave rdata unchanged; err=0 on success.
REQ-023 req_valid while req_ready=0 is ignored (not queued).
REQ-024 AWREADY/WREADY/ARREADY/RVALID ignored when the matching VALID/READY is low.
REQ-025 Never more than one outstanding AXI transaction; AW/W and AR never active together.

Reset
REQ-026 ARESET sampled high: state=CFG, AWVALID=WVALID=ARVALID=RREADY=0, AWADDR=ARADDR=WDATA=0, req_ready=0, done=0, err=0, rdata=8'h00, counters=0.
REQ-027 ARESET mid-transaction aborts immediately (VALIDs dropped next edge, no completion); CFG re-runs after release.

Verification
REQ-028 Reset release, AWREADY/WREADY tied 1 -> one write BASE+0x8 data 32'h30000000, then req_ready=1.
REQ-029 Write addr 16'h00F0 data 8'hAA, BUSY=0 on first poll, TWC_CYCLES=100 -> TX writes 0x06, poll, 0x02,0x00,0xF0,0xAA, poll, done after 100 idle cycles, err=0.
REQ-030 Read addr 16'h00F0, model RX returns 0xFF,0xFF,0xFF,0xAA -> TX writes 0x03,0x00,0xF0,0x00, 4 RX reads, done with rdata=8'hAA.
REQ-031 AWREADY 3 cycles before WREADY, ARREADY/RVALID delayed 5 cycles -> VALIDs held stable, single transfer per byte, same byte order.
REQ-032 BUSY stuck 1, POLL_LIMIT=8 -> exactly 8 status reads, done with err=1, no further TX writes.
REQ-033 ARESET asserted during frame B -> all VALIDs 0 next cycle, CFG write repeats, req_ready=1 afterwards, no done pulse.

Source files
------------

// File: rtl/spi_eeprom_sequencer.sv
// SPI EEPROM byte sequencer driving an AXI-Lite SPI peripheral.
// After reset it writes CMD_WORD to the peripheral command register, then
// accepts single-byte read/write requests and turns them into SPI frames
// pushed through the TX FIFO, polling STATUS.BUSY between frames.
// Ports:
//   ACLK, ARESET              clock, synchronous active-high reset
//   req_valid/req_ready       request handshake; req_write/req_addr/req_wdata
//   done/rdata/err            one-cycle completion pulse with read byte / timeout flag
//   AW*/W*                    AXI-Lite write address/data (no B channel)
//   AR*/R*                    AXI-Lite read address/data
module spi_eeprom_sequencer #(
  parameter logic [31:0] BASE_ADDRESS = 32'hFFFF0000,
  parameter logic [31:0] CMD_WORD     = 32'h30000000,
  parameter int unsigned TWC_CYCLES   = 500000,
  parameter int unsigned POLL_LIMIT   = 4096
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        done,
  output logic [7:0]  rdata,
  output logic        err,
  output logic        AWVALID,
  input  logic        AWREADY,
  output logic [31:0] AWADDR,
  output logic        WVALID,
  input  logic        WREADY,
  output logic [31:0] WDATA,
  output logic        ARVALID,
  input  logic        ARREADY,
  output logic [31:0] ARADDR,
  input  logic        RVALID,
  output logic        RREADY,
  input  logic [31:0] RDATA
);

  localparam logic [31:0] RX_ADDR     = BASE_ADDRESS;
  localparam logic [31:0] STATUS_ADDR = BASE_ADDRESS + 32'h4;
  localparam logic [31:0] CMD_ADDR    = BASE_ADDRESS + 32'h8;
  localparam logic [31:0] TX_ADDR     = BASE_ADDRESS + 32'hC;

  localparam int unsigned TW = $clog2(TWC_CYCLES + 1);
  localparam int unsigned PW = $clog2(POLL_LIMIT + 1);
  localparam logic [TW-1:0] TWC_LAST  = TW'(TWC_CYCLES - 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_LIMIT - 1);

  typedef enum logic [3:0] {
    CFG, IDLE, PUSH, POLL_AR, POLL_R, DRAIN_AR, DRAIN_R, TWC, DONE
  } state_t;

  state_t        state;
  logic          wr_busy;    // an AW/W pair has been issued and is not yet complete
  logic          lat_write;
  logic [15:0]   lat_addr;
  logic [7:0]    lat_wdata;
  logic          frame_b;    // write request: 0 = WREN frame, 1 = program frame
  logic [1:0]    byte_idx;
  logic [1:0]    drain_cnt;
  logic [PW-1:0] poll_cnt;
  logic [TW-1:0] twc_cnt;
  logic [7:0]    tx_byte;
  logic          last_byte;
  logic          wr_fire;
  logic          unused_rdata;

  assign unused_rdata = ^RDATA[31:8];

  always_comb begin
    tx_byte = 8'h00;
    case (byte_idx)
      2'd0:    tx_byte = !lat_write ? 8'h03 : (frame_b ? 8'h02 : 8'h06);
      2'd1:    tx_byte = lat_addr[15:8];
      2'd2:    tx_byte = lat_addr[7:0];
      default: tx_byte = lat_write ? lat_wdata : 8'h00;
    endcase
  end

  assign last_byte = (lat_write && !frame_b) || (byte_idx == 2'd3);
  // Both channels are done once each VALID is either already low or being accepted now.
  assign wr_fire   = (!AWVALID || AWREADY) && (!WVALID || WREADY);

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state     <= CFG;
      wr_busy   <= 1'b0;
      AWVALID   <= 1'b0;
      WVALID    <= 1'b0;
      ARVALID   <= 1'b0;
      RREADY    <= 1'b0;
      AWADDR    <= '0;
      WDATA     <= '0;
      ARADDR    <= '0;
      req_ready <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      rdata     <= 8'h00;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      frame_b   <= 1'b0;
      byte_idx  <= '0;
      drain_cnt <= '0;
      poll_cnt  <= '0;
      twc_cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        CFG, PUSH: begin
          if (!wr_busy) begin
            AWVALID <= 1'b1;
            WVALID  <= 1'b1;
            AWADDR  <= (state == CFG) ? CMD_ADDR : TX_ADDR;
            WDATA   <= (state == CFG) ? CMD_WORD : {24'h0, tx_byte};
            wr_busy <= 1'b1;
          end else begin
            if (AWREADY) AWVALID <= 1'b0;
            if (WREADY)  WVALID  <= 1'b0;
            if (wr_fire) begin
              wr_busy <= 1'b0;
              if (state == CFG) begin
                state     <= IDLE;
                req_ready <= 1'b1;
              end else if (last_byte) begin
                state    <= POLL_AR;
                poll_cnt <= '0;
              end else begin
                byte_idx <= byte_idx + 2'd1;
              end
            end
          end
        end
        IDLE: begin
          if (req_valid) begin
            lat_write <= req_write;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            req_ready <= 1'b0;
            frame_b   <= 1'b0;
            byte_idx  <= '0;
            state     <= PUSH;
          end
        end
        POLL_AR, DRAIN_AR: begin
          if (!ARVALID) begin
            ARVALID <= 1'b1;
            ARADDR  <= (state == POLL_AR) ? STATUS_ADDR : RX_ADDR;
          end else if (ARREADY) begin
            ARVALID <= 1'b0;
            RREADY  <= 1'b1;
            state   <= (state == POLL_AR) ? POLL_R : DRAIN_R;
          end
        end
        POLL_R: begin
          if (RVALID) begin
            RREADY   <= 1'b0;
            poll_cnt <= poll_cnt + 1'b1;
            if (!RDATA[0]) begin
              if (!lat_write) begin
                state     <= DRAIN_AR;
                drain_cnt <= '0;
              end else if (!frame_b) begin
                state    <= PUSH;
                frame_b  <= 1'b1;
                byte_idx <= '0;
              end else begin
                state   <= TWC;
                twc_cnt <= '0;
              end
            end else if (poll_cnt == POLL_LAST) begin
              state <= DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              state <= POLL_AR;
            end
          end
        end
        DRAIN_R: begin
          if (RVALID) begin
            RREADY <= 1'b0;
            // Only the byte clocked in during the 4th (data) slot is meaningful.
            if (drain_cnt == 2'd3) begin
              rdata <= RDATA[7:0];
              state <= DONE;
              done  <= 1'b1;
            end else begin
              drain_cnt <= drain_cnt + 2'd1;
              state     <= DRAIN_AR;
            end
          end
        end
        TWC: begin
          if (twc_cnt == TWC_LAST) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            twc_cnt <= twc_cnt + 1'b1;
          end
        end
        DONE: begin
          err       <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= CFG;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_eeprom_sequencer.sv
// Scoreboard bench for spi_eeprom_sequencer: stimulus pushes expected AXI
// writes, status/RX reads and done responses; an AXI-Lite slave model and a
// done monitor pop and compare as the DUT presents them.
module tb_spi_eeprom_sequencer;

  localparam logic [31:0] BASE   = 32'hFFFF0000;
  localparam logic [31:0] RX_A   = BASE;
  localparam logic [31:0] STAT_A = BASE + 32'h4;
  localparam logic [31:0] CMD_A  = BASE + 32'h8;
  localparam logic [31:0] TX_A   = BASE + 32'hC;
  localparam int unsigned TWC    = 100;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [15:0] req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic        done;
  logic [7:0]  rdata;
  logic        err;
  logic        AWVALID, WVALID, ARVALID, RREADY;
  logic        AWREADY = 1'b0, WREADY = 1'b0, ARREADY = 1'b0, RVALID = 1'b0;
  logic [31:0] AWADDR, WDATA, ARADDR;
  logic [31:0] RDATA = '0;

  spi_eeprom_sequencer #(.TWC_CYCLES(TWC), .POLL_LIMIT(8)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .done(done), .rdata(rdata), .err(err),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA)
  );

  always #5 ACLK = ~ACLK;

  typedef struct packed { logic [31:0] addr; logic [31:0] data; } wr_t;
  typedef struct packed { logic [7:0] rd; logic er; logic chk_twc; } resp_t;

  wr_t         exp_wr[$];
  logic [31:0] exp_rd[$];
  resp_t       exp_resp[$];
  logic        status_q[$];
  logic [7:0]  rx_q[$];
  logic [31:0] aw_log[$], w_log[$];

  int unsigned total = 0, bad = 0;
  int unsigned cyc = 0, last_r_cyc = 0, done_cnt = 0;
  int unsigned aw_delay = 0, w_delay = 0, ar_delay = 0, r_delay = 0;
  int unsigned aw_wait = 0, w_wait = 0, ar_wait = 0, r_wait = 0;
  logic        stuck_busy = 1'b0;
  logic        r_pend = 1'b0;
  logic [31:0] r_data = '0;
  logic        hold_aw = 0, hold_w = 0, hold_ar = 0;
  logic [31:0] hold_awaddr = '0, hold_wdata = '0, hold_araddr = '0;
  logic [7:0]  rdata_m = 8'h00;

  always @(posedge ACLK) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // AXI-Lite slave model: READY/RVALID decided at negedge for the next posedge.
  always @(negedge ACLK) begin
    if (ARESET) begin
      AWREADY = (aw_delay == 0); WREADY = (w_delay == 0); ARREADY = (ar_delay == 0);
      RVALID = 1'b0; RDATA = 32'hDEADBEEF;
      aw_wait = 0; w_wait = 0; ar_wait = 0; r_wait = 0; r_pend = 1'b0;
      hold_aw = 0; hold_w = 0; hold_ar = 0;
      aw_log.delete(); w_log.delete();
    end else begin
      if (hold_aw) begin chk("aw_valid_hold", AWVALID, 1); chk("awaddr_stable", AWADDR, hold_awaddr); end
      if (hold_w)  begin chk("w_valid_hold", WVALID, 1);   chk("wdata_stable", WDATA, hold_wdata); end
      if (hold_ar) begin chk("ar_valid_hold", ARVALID, 1); chk("araddr_stable", ARADDR, hold_araddr); end
      if (AWVALID || WVALID || ARVALID || RREADY)
        chk("wr_rd_exclusive", (AWVALID || WVALID) && (ARVALID || RREADY), 0);

      if (r_pend && RREADY) begin
        if (r_wait >= r_delay) begin
          RVALID = 1'b1; RDATA = r_data; r_pend = 1'b0; last_r_cyc = cyc;
        end else begin
          RVALID = 1'b0; RDATA = 32'hDEADBEEF; r_wait++;
        end
      end else begin
        RVALID = 1'b0; RDATA = 32'hDEADBEEF;
      end

      hold_ar = 0;
      if (ARVALID) begin
        if (ar_wait >= ar_delay) begin
          ARREADY = 1'b1; ar_wait = 0;
          if (exp_rd.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_read actual=%h required=none", ARADDR);
          end else chk("axi_rd_addr", ARADDR, exp_rd.pop_front());
          if (ARADDR == STAT_A)
            r_data = {24'hA5A5A5, 7'h7F, (status_q.size() != 0) ? status_q.pop_front() : stuck_busy};
          else if (ARADDR == RX_A)
            r_data = {24'hC3C3C3, (rx_q.size() != 0) ? rx_q.pop_front() : 8'hEE};
          else r_data = '0;
          r_pend = 1'b1; r_wait = 0;
        end else begin
          ARREADY = 1'b0; ar_wait++; hold_ar = 1; hold_araddr = ARADDR;
        end
      end else begin
        ARREADY = (ar_delay == 0); ar_wait = 0;
      end

      hold_aw = 0;
      if (AWVALID) begin
        if (aw_wait >= aw_delay) begin AWREADY = 1'b1; aw_log.push_back(AWADDR); aw_wait = 0; end
        else begin AWREADY = 1'b0; aw_wait++; hold_aw = 1; hold_awaddr = AWADDR; end
      end else begin
        AWREADY = (aw_delay == 0); aw_wait = 0;
      end

      hold_w = 0;
      if (WVALID) begin
        if (w_wait >= w_delay) begin WREADY = 1'b1; w_log.push_back(WDATA); w_wait = 0; end
        else begin WREADY = 1'b0; w_wait++; hold_w = 1; hold_wdata = WDATA; end
      end else begin
        WREADY = (w_delay == 0); w_wait = 0;
      end

      while (aw_log.size() != 0 && w_log.size() != 0) begin
        logic [31:0] a, d;
        a = aw_log.pop_front();
        d = w_log.pop_front();
        if (exp_wr.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_write actual=%h/%h required=none", a, d);
        end else begin
          wr_t e;
          e = exp_wr.pop_front();
          chk("axi_wr_addr", a, e.addr);
          chk("axi_wr_data", d, e.data);
        end
      end
    end
  end

  // Done monitor.
  always @(negedge ACLK) begin
    if (!ARESET && done) begin
      done_cnt++;
      if (exp_resp.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_done actual=1 required=0 (t=%0t)", $time);
      end else begin
        resp_t r;
        r = exp_resp.pop_front();
        chk("done_rdata", rdata, r.rd);
        chk("done_err", err, r.er);
        if (r.chk_twc) chk("twc_length", cyc - last_r_cyc, TWC + 1);
      end
    end
  end

  task automatic push_tx(input logic [7:0] b);
    exp_wr.push_back({TX_A, 24'h0, b});
  endtask

  task automatic push_polls(input int unsigned nbusy);
    for (int unsigned i = 0; i < nbusy; i++) begin status_q.push_back(1'b1); exp_rd.push_back(STAT_A); end
    status_q.push_back(1'b0);
    exp_rd.push_back(STAT_A);
  endtask

  task automatic exp_write_req(input logic [15:0] a, input logic [7:0] d,
                               input int unsigned busy_a, input int unsigned busy_b);
    push_tx(8'h06);
    push_polls(busy_a);
    push_tx(8'h02); push_tx(a[15:8]); push_tx(a[7:0]); push_tx(d);
    push_polls(busy_b);
    exp_resp.push_back({rdata_m, 1'b0, 1'b1});
  endtask

  task automatic exp_read_req(input logic [15:0] a, input logic [7:0] r0, input logic [7:0] r1,
                              input logic [7:0] r2, input logic [7:0] r3, input int unsigned busy);
    push_tx(8'h03); push_tx(a[15:8]); push_tx(a[7:0]); push_tx(8'h00);
    push_polls(busy);
    for (int unsigned i = 0; i < 4; i++) exp_rd.push_back(RX_A);
    rx_q.push_back(r0); rx_q.push_back(r1); rx_q.push_back(r2); rx_q.push_back(r3);
    rdata_m = r3;
    exp_resp.push_back({r3, 1'b0, 1'b0});
  endtask

  task automatic tick();
    @(posedge ACLK); #1;
  endtask

  task automatic wait_ready(input int unsigned lim);
    int unsigned n = 0;
    while (!req_ready && n < lim) begin tick(); n++; end
    chk("req_ready_up", req_ready, 1);
  endtask

  task automatic do_req(input logic w, input logic [15:0] a, input logic [7:0] d);
    wait_ready(300);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    tick();
    req_valid = 1'b0;
    chk("req_ready_drop", req_ready, 0);
  endtask

  task automatic wait_done(input int unsigned lim);
    int unsigned start = done_cnt;
    int unsigned n = 0;
    while (done_cnt == start && n < lim) begin tick(); n++; end
    chk("done_seen", done_cnt - start, 1);
  endtask

  task automatic check_empty(input string tag);
    chk({tag, "_wr_left"}, exp_wr.size(), 0);
    chk({tag, "_rd_left"}, exp_rd.size(), 0);
    chk({tag, "_resp_left"}, exp_resp.size(), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned n;
    repeat (4) tick();
    chk("rst_awvalid", AWVALID, 0);
    chk("rst_wvalid", WVALID, 0);
    chk("rst_arvalid", ARVALID, 0);
    chk("rst_rready", RREADY, 0);
    chk("rst_awaddr", AWADDR, 0);
    chk("rst_wdata", WDATA, 0);
    chk("rst_araddr", ARADDR, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_rdata", rdata, 0);

    // Configuration write, then ready.
    exp_wr.push_back({CMD_A, 32'h30000000});
    ARESET = 1'b0;
    wait_ready(50);
    check_empty("cfg");

    // Write 0x00F0 <= 0xAA, BUSY clear on first poll.
    exp_write_req(16'h00F0, 8'hAA, 0, 0);
    do_req(1'b1, 16'h00F0, 8'hAA);
    wait_done(1000);
    check_empty("wr");

    // Read 0x00F0.
    exp_read_req(16'h00F0, 8'hFF, 8'hFF, 8'hFF, 8'hAA, 0);
    do_req(1'b0, 16'h00F0, 8'h00);
    wait_done(1000);
    check_empty("rd");

    // Slow slave, repeated BUSY polls, ignored request while busy.
    aw_delay = 2; w_delay = 5; ar_delay = 5; r_delay = 5;
    tick();
    exp_write_req(16'h1234, 8'h5C, 2, 0);
    do_req(1'b1, 16'h1234, 8'h5C);
    tick(); tick();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'hBEEF;
    tick();
    req_valid = 1'b0;
    wait_done(3000);
    check_empty("slow_wr");
    exp_read_req(16'h1234, 8'h11, 8'h22, 8'h33, 8'h5C, 1);
    do_req(1'b0, 16'h1234, 8'h00);
    wait_done(3000);
    check_empty("slow_rd");

    // BUSY stuck: exactly 8 polls then err, no program frame.
    aw_delay = 0; w_delay = 0; ar_delay = 0; r_delay = 0;
    stuck_busy = 1'b1;
    tick();
    push_tx(8'h06);
    for (int unsigned i = 0; i < 8; i++) exp_rd.push_back(STAT_A);
    exp_resp.push_back({rdata_m, 1'b1, 1'b0});
    do_req(1'b1, 16'h0042, 8'h77);
    wait_done(500);
    repeat (30) tick();
    check_empty("timeout");
    chk("err_cleared", err, 0);
    stuck_busy = 1'b0;

    // Reset during program frame.
    aw_delay = 2; w_delay = 2;
    tick();
    exp_write_req(16'h0300, 8'h55, 0, 0);
    do_req(1'b1, 16'h0300, 8'h55);
    n = 0;
    while (!(AWVALID && WDATA == 32'h3) && n < 500) begin tick(); n++; end
    chk("frame_b_reached", AWVALID && WDATA == 32'h3, 1);
    ARESET = 1'b1;
    tick();
    chk("abort_awvalid", AWVALID, 0);
    chk("abort_wvalid", WVALID, 0);
    chk("abort_arvalid", ARVALID, 0);
    chk("abort_rready", RREADY, 0);
    chk("abort_req_ready", req_ready, 0);
    exp_wr.delete(); exp_rd.delete(); exp_resp.delete(); status_q.delete(); rx_q.delete();
    rdata_m = 8'h00;
    exp_wr.push_back({CMD_A, 32'h30000000});
    tick();
    aw_delay = 0; w_delay = 0;
    ARESET = 1'b0;
    wait_ready(50);
    chk("post_rst_rdata", rdata, 0);
    check_empty("rst");

    exp_read_req(16'h0300, 8'h01, 8'h02, 8'h03, 8'h9E, 0);
    do_req(1'b0, 16'h0300, 8'h00);
    wait_done(1000);
    repeat (10) tick();
    check_empty("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
